// File: rtl/taxi_axil_reg_bridge_if.sv
// AXI4-lite bundle with separate write (AW/W/B) and read (AR/R) modports.
// Latency: none, plain wires.
// Backpressure: standard AXI valid/ready on every channel.
// Params: DATA_W data width, ADDR_W bus address width (STRB_W = DATA_W/8 derived).
// Modports: wr_slv/wr_mst carry AW, W, B; rd_slv/rd_mst carry AR, R.
interface taxi_axil_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport wr_slv (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
  modport wr_mst (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );
  modport rd_slv (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
  modport rd_mst (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/taxi_axil_reg_bridge.sv
// AXI4-lite slave to single-outstanding register bus bridge, independent write and read paths.
// Latency: request strobe 1 cycle after address/data handshake; response 1 cycle after ack or timeout.
// Backpressure: one transaction per path; readies drop while a transaction is held, B/R held until ready.
// Ports: clk, rst (sync, active high); s_axil_wr (AW/W/B slave), s_axil_rd (AR/R slave);
//   reg_wr_addr/data/strb/en out, reg_wr_wait/ack in; reg_rd_addr/en out, reg_rd_data/wait/ack in.
// Option: define TAXI_AXIL_REG_BRIDGE_SLVERR_EN to report SLVERR on timed-out transactions.
module taxi_axil_reg_bridge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int TIMEOUT = 16,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  taxi_axil_if.wr_slv       s_axil_wr,
  taxi_axil_if.rd_slv       s_axil_rd,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic [STRB_W-1:0] reg_wr_strb,
  output logic              reg_wr_en,
  input  logic              reg_wr_wait,
  input  logic              reg_wr_ack,
  output logic [ADDR_W-1:0] reg_rd_addr,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rd_data,
  input  logic              reg_rd_wait,
  input  logic              reg_rd_ack
);
  localparam int LSB_W = $clog2(STRB_W);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((1 << LSB_W) - 1);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef TAXI_AXIL_REG_BRIDGE_SLVERR_EN
  localparam logic [1:0] RESP_TO = 2'b10;
`else
  localparam logic [1:0] RESP_TO = 2'b00;
`endif

  // protection bits and address bits beyond the register window carry no meaning here
  logic unused_bits;
  assign unused_bits = &{1'b0, s_axil_wr.awprot, s_axil_rd.arprot, s_axil_wr.awaddr, s_axil_rd.araddr};

  // ---------------- write path ----------------
  typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_ACCESS, WR_RESP} wr_state_t;
  wr_state_t wr_state, wr_state_n;
  logic aw_got, w_got, aw_hs, w_hs, wr_expire;
  logic awready_c, wready_c, bvalid_c, wr_en_c;
  logic [CNT_W-1:0] wr_cnt;
  logic [1:0] bresp_q;

  always_ff @(posedge clk) begin
    if (rst) wr_state <= WR_IDLE;
    else     wr_state <= wr_state_n;
  end

  always_comb begin
    wr_state_n = wr_state;
    awready_c  = 1'b0;
    wready_c   = 1'b0;
    bvalid_c   = 1'b0;
    wr_en_c    = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    wr_expire  = 1'b0;
    case (wr_state)
      WR_IDLE, WR_ACCEPT: begin
        // each channel closes independently once captured
        awready_c = !aw_got;
        wready_c  = !w_got;
        aw_hs     = awready_c && s_axil_wr.awvalid;
        w_hs      = wready_c && s_axil_wr.wvalid;
        if ((aw_got || aw_hs) && (w_got || w_hs)) wr_state_n = WR_ACCESS;
        else if (aw_hs || w_hs)                   wr_state_n = WR_ACCEPT;
      end
      WR_ACCESS: begin
        wr_en_c = 1'b1;
        // expiry yields to an ack in the same cycle
        wr_expire = (TIMEOUT != 0) && !reg_wr_ack && !reg_wr_wait && (wr_cnt == CNT_LAST);
        if (reg_wr_ack || wr_expire) wr_state_n = WR_RESP;
      end
      WR_RESP: begin
        bvalid_c = 1'b1;
        if (s_axil_wr.bready) wr_state_n = WR_IDLE;
      end
      default: wr_state_n = WR_IDLE;
    endcase
    if (rst) begin
      awready_c = 1'b0;
      wready_c  = 1'b0;
      bvalid_c  = 1'b0;
      wr_en_c   = 1'b0;
      aw_hs     = 1'b0;
      w_hs      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      wr_cnt      <= '0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      reg_wr_strb <= '0;
      bresp_q     <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_got      <= 1'b1;
        reg_wr_addr <= s_axil_wr.awaddr[ADDR_W-1:0] & ADDR_MASK;
      end
      if (w_hs) begin
        w_got       <= 1'b1;
        reg_wr_data <= s_axil_wr.wdata;
        reg_wr_strb <= s_axil_wr.wstrb;
      end
      if (wr_state == WR_ACCESS) begin
        if (reg_wr_wait)      wr_cnt <= '0;
        else if (!reg_wr_ack) wr_cnt <= wr_cnt + CNT_W'(1);
        if (reg_wr_ack || wr_expire) begin
          aw_got  <= 1'b0;
          w_got   <= 1'b0;
          wr_cnt  <= '0;
          bresp_q <= wr_expire ? RESP_TO : RESP_OKAY;
        end
      end
    end
  end

  assign s_axil_wr.awready = awready_c;
  assign s_axil_wr.wready  = wready_c;
  assign s_axil_wr.bvalid  = bvalid_c;
  assign s_axil_wr.bresp   = bresp_q;
  assign reg_wr_en         = wr_en_c;

  // ---------------- read path ----------------
  typedef enum logic [1:0] {RD_IDLE, RD_ACCESS, RD_RESP} rd_state_t;
  rd_state_t rd_state, rd_state_n;
  logic ar_hs, rd_expire, arready_c, rvalid_c, rd_en_c;
  logic [CNT_W-1:0] rd_cnt;
  logic [1:0] rresp_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) rd_state <= RD_IDLE;
    else     rd_state <= rd_state_n;
  end

  always_comb begin
    rd_state_n = rd_state;
    arready_c  = 1'b0;
    rvalid_c   = 1'b0;
    rd_en_c    = 1'b0;
    ar_hs      = 1'b0;
    rd_expire  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        arready_c = 1'b1;
        ar_hs     = s_axil_rd.arvalid;
        if (ar_hs) rd_state_n = RD_ACCESS;
      end
      RD_ACCESS: begin
        rd_en_c   = 1'b1;
        rd_expire = (TIMEOUT != 0) && !reg_rd_ack && !reg_rd_wait && (rd_cnt == CNT_LAST);
        if (reg_rd_ack || rd_expire) rd_state_n = RD_RESP;
      end
      RD_RESP: begin
        rvalid_c = 1'b1;
        if (s_axil_rd.rready) rd_state_n = RD_IDLE;
      end
      default: rd_state_n = RD_IDLE;
    endcase
    if (rst) begin
      arready_c = 1'b0;
      rvalid_c  = 1'b0;
      rd_en_c   = 1'b0;
      ar_hs     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt      <= '0;
      reg_rd_addr <= '0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
    end else begin
      if (ar_hs) reg_rd_addr <= s_axil_rd.araddr[ADDR_W-1:0] & ADDR_MASK;
      if (rd_state == RD_ACCESS) begin
        if (reg_rd_wait)      rd_cnt <= '0;
        else if (!reg_rd_ack) rd_cnt <= rd_cnt + CNT_W'(1);
        if (reg_rd_ack) begin
          rd_cnt  <= '0;
          rdata_q <= reg_rd_data;
          rresp_q <= RESP_OKAY;
        end else if (rd_expire) begin
          rd_cnt  <= '0;
          rdata_q <= '0;
          rresp_q <= RESP_TO;
        end
      end
    end
  end

  assign s_axil_rd.arready = arready_c;
  assign s_axil_rd.rvalid  = rvalid_c;
  assign s_axil_rd.rresp   = rresp_q;
  assign s_axil_rd.rdata   = rdata_q;
  assign reg_rd_en         = rd_en_c;
endmodule

// File: tb/tb_taxi_axil_reg_bridge.sv
// Testbench for taxi_axil_reg_bridge: random and directed AXI4-lite traffic against a register responder.
// Latency: expected access length and response come from a cycle-count model of ack/wait/timeout.
// Backpressure: random valid and bready/rready delays; a monitor checks readies and held responses.
module tb_taxi_axil_reg_bridge;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 16;
`ifdef TAXI_AXIL_REG_BRIDGE_SLVERR_EN
  localparam logic [1:0] TO_RESP = 2'b10;
`else
  localparam logic [1:0] TO_RESP = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  taxi_axil_if #(.DATA_W(DATA_W), .ADDR_W(32)) axil ();

  logic [ADDR_W-1:0] reg_wr_addr, reg_rd_addr;
  logic [DATA_W-1:0] reg_wr_data, reg_rd_data;
  logic [3:0]        reg_wr_strb;
  logic reg_wr_en, reg_wr_wait, reg_wr_ack, reg_rd_en, reg_rd_wait, reg_rd_ack;

  taxi_axil_reg_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .s_axil_wr(axil), .s_axil_rd(axil),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en), .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string got, input string req);
    checks++;
    errors++;
    $display("FAIL %s: got %s, required %s", name, got, req);
  endtask

  // Access length in cycles and timeout flag: wait holds the count at zero for
  // the first wt cycles, then TIMEOUT idle cycles expire unless ack comes first
  // (d == 0 means no ack ever).
  function automatic int model_cycles(input int d, input int wt, output bit to);
    if (d == 0 || d > wt + TIMEOUT) begin
      to = 1'b1;
      return wt + TIMEOUT;
    end
    to = 1'b0;
    return d;
  endfunction

  typedef struct {logic [15:0] addr; logic [31:0] data; logic [3:0] strb; int cyc;} wreg_t;
  typedef struct {logic [15:0] addr; int cyc;} rreg_t;
  wreg_t exp_wreg[$];
  rreg_t exp_rreg[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  // register-side responder configuration (d == 0: never ack)
  int wr_d = 1, wr_wt = 0, rd_d = 1, rd_wt = 0;
  logic [31:0] rd_val = '0;

  initial begin
    int wc, rc;
    wc = 0;
    rc = 0;
    reg_wr_ack = 1'b0; reg_wr_wait = 1'b0;
    reg_rd_ack = 1'b0; reg_rd_wait = 1'b0; reg_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      wc = reg_wr_en ? wc + 1 : 0;
      rc = reg_rd_en ? rc + 1 : 0;
      reg_wr_ack  = reg_wr_en && wr_d != 0 && wc == wr_d;
      reg_wr_wait = reg_wr_en && wc <= wr_wt;
      reg_rd_ack  = reg_rd_en && rd_d != 0 && rc == rd_d;
      reg_rd_wait = reg_rd_en && rc <= rd_wt;
      reg_rd_data = rd_val;
    end
  end

  // monitor: pops expectations whenever the DUT presents a response or request
  bit aw_taken, w_taken, ar_taken, b_stall, r_stall, in_wen, in_ren;
  logic [1:0]  b_stall_resp, eb;
  logic [33:0] r_stall_val, er;
  int wen_cyc, ren_cyc, wen_exp, ren_exp;
  wreg_t ew;
  rreg_t erd;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_taken = 0; w_taken = 0; ar_taken = 0; b_stall = 0; r_stall = 0;
        in_wen = 0; in_ren = 0;
      end else begin
        check("awready", 64'(axil.awready), 64'(!aw_taken));
        check("wready",  64'(axil.wready),  64'(!w_taken));
        check("arready", 64'(axil.arready), 64'(!ar_taken));
        if (b_stall) check("b_hold", 64'({axil.bvalid, axil.bresp}), 64'({1'b1, b_stall_resp}));
        if (r_stall) check("r_hold", 64'({axil.rvalid, axil.rresp, axil.rdata}), 64'({1'b1, r_stall_val}));
        if (axil.awvalid && axil.awready) aw_taken = 1;
        if (axil.wvalid && axil.wready)   w_taken = 1;
        if (axil.arvalid && axil.arready) ar_taken = 1;
        if (axil.bvalid && axil.bready) begin
          if (exp_b.size() == 0) flag("unexpected_b", "B response", "none");
          else begin
            eb = exp_b.pop_front();
            check("bresp", 64'(axil.bresp), 64'(eb));
          end
          aw_taken = 0; w_taken = 0;
        end
        if (axil.rvalid && axil.rready) begin
          if (exp_r.size() == 0) flag("unexpected_r", "R response", "none");
          else begin
            er = exp_r.pop_front();
            check("rresp_rdata", 64'({axil.rresp, axil.rdata}), 64'(er));
          end
          ar_taken = 0;
        end
        b_stall = axil.bvalid && !axil.bready;
        b_stall_resp = axil.bresp;
        r_stall = axil.rvalid && !axil.rready;
        r_stall_val = {axil.rresp, axil.rdata};
        if (reg_wr_en) begin
          if (!in_wen) begin
            in_wen = 1; wen_cyc = 1; wen_exp = -1;
            if (exp_wreg.size() == 0) flag("unexpected_reg_wr", "reg_wr_en", "idle");
            else begin
              ew = exp_wreg.pop_front();
              wen_exp = ew.cyc;
              check("reg_wr_addr", 64'(reg_wr_addr), 64'(ew.addr));
              check("reg_wr_data", 64'(reg_wr_data), 64'(ew.data));
              check("reg_wr_strb", 64'(reg_wr_strb), 64'(ew.strb));
            end
          end else wen_cyc++;
        end else if (in_wen) begin
          in_wen = 0;
          check("reg_wr_en_cycles", 64'(wen_cyc), 64'(wen_exp));
        end
        if (reg_rd_en) begin
          if (!in_ren) begin
            in_ren = 1; ren_cyc = 1; ren_exp = -1;
            if (exp_rreg.size() == 0) flag("unexpected_reg_rd", "reg_rd_en", "idle");
            else begin
              erd = exp_rreg.pop_front();
              ren_exp = erd.cyc;
              check("reg_rd_addr", 64'(reg_rd_addr), 64'(erd.addr));
            end
          end else ren_cyc++;
        end else if (in_ren) begin
          in_ren = 0;
          check("reg_rd_en_cycles", 64'(ren_cyc), 64'(ren_exp));
        end
      end
    end
  end

  task automatic send_aw(input logic [31:0] addr, input int dly);
    int n = 0;
    repeat (dly) begin @(posedge clk); #1; end
    axil.awaddr = addr; axil.awprot = 3'($urandom_range(0, 7)); axil.awvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (axil.awready) break;
      n++;
      if (n > 300) begin flag("aw_handshake", "no awready", "awready"); break; end
    end
    @(posedge clk); #1;
    axil.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    int n = 0;
    repeat (dly) begin @(posedge clk); #1; end
    axil.wdata = data; axil.wstrb = strb; axil.wvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (axil.wready) break;
      n++;
      if (n > 300) begin flag("w_handshake", "no wready", "wready"); break; end
    end
    @(posedge clk); #1;
    axil.wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int d, input int wt, input int b_dly);
    int acc, n;
    bit to;
    acc = model_cycles(d, wt, to);
    wr_d = d; wr_wt = wt;
    exp_wreg.push_back('{addr[15:0] & 16'hFFFC, data, strb, acc});
    exp_b.push_back(to ? TO_RESP : 2'b00);
    fork
      send_aw(addr, aw_dly);
      send_w(data, strb, w_dly);
    join
    n = 0;
    do begin @(negedge clk); n++; end while (!axil.bvalid && n < 300);
    check("b_latency", 64'(n), 64'(acc + 1));
    @(posedge clk); #1;
    repeat (b_dly) begin @(posedge clk); #1; end
    axil.bready = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (axil.bvalid) break;
      n++;
      if (n > 300) begin flag("b_handshake", "no bvalid", "bvalid"); break; end
    end
    @(posedge clk); #1;
    axil.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int d, input int wt,
                         input logic [31:0] data, input int r_dly);
    int acc, n;
    bit to;
    acc = model_cycles(d, wt, to);
    rd_d = d; rd_wt = wt; rd_val = data;
    exp_rreg.push_back('{addr[15:0] & 16'hFFFC, acc});
    exp_r.push_back(to ? {TO_RESP, 32'h0} : {2'b00, data});
    repeat (ar_dly) begin @(posedge clk); #1; end
    axil.araddr = addr; axil.arprot = 3'($urandom_range(0, 7)); axil.arvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (axil.arready) break;
      n++;
      if (n > 300) begin flag("ar_handshake", "no arready", "arready"); break; end
    end
    @(posedge clk); #1;
    axil.arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!axil.rvalid && n < 300);
    check("r_latency", 64'(n), 64'(acc + 1));
    @(posedge clk); #1;
    repeat (r_dly) begin @(posedge clk); #1; end
    axil.rready = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (axil.rvalid) break;
      n++;
      if (n > 300) begin flag("r_handshake", "no rvalid", "rvalid"); break; end
    end
    @(posedge clk); #1;
    axil.rready = 1'b0;
  endtask

  function automatic int rand_d();
    return ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
  endfunction

  function automatic int rand_wt();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 25)) : 0;
  endfunction

  initial begin
    int n;
    axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b0;
    axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0; axil.bready = 1'b0;
    axil.araddr = '0; axil.arprot = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 64'({axil.awready, axil.wready, axil.bvalid, axil.arready, axil.rvalid, reg_wr_en, reg_rd_en}), 64'(0));
    check("rst_wr_regs", 64'({reg_wr_addr, reg_wr_data, reg_wr_strb}), 64'(0));
    check("rst_rd_regs", 64'({reg_rd_addr, axil.bresp, axil.rresp, axil.rdata}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // minimum latency write, then W well ahead of AW with a stalled B
    do_write(32'h0000_1236, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, 0, 0);
    do_write(32'h0000_2008, 32'h1234_5678, 4'h3, 3, 0, 1, 0, 5);
    // read acked after three cycles
    do_read(32'h0000_0040, 0, 3, 0, 32'hA5A5_0001, 0);
    // no ack: timeout on both paths
    fork
      do_write(32'h0000_0100, 32'h0000_0011, 4'h1, 0, 0, 0, 0, 1);
      do_read(32'h0000_0200, 0, 0, 0, 32'h7777_7777, 2);
    join
    // long wait holds the counter, then ack
    fork
      do_write(32'h0000_0104, 32'h0000_0022, 4'h2, 0, 1, 41, 40, 0);
      do_read(32'h0000_0204, 0, 41, 40, 32'h1111_2222, 0);
    join
    // ack on the expiry cycle wins; one cycle later loses
    fork
      do_write(32'h0000_0108, 32'h0000_0033, 4'h4, 0, 0, TIMEOUT, 0, 0);
      do_read(32'h0000_0208, 0, TIMEOUT, 0, 32'h5EED_0001, 0);
    join
    fork
      do_write(32'h0000_010C, 32'h0000_0044, 4'h8, 0, 0, TIMEOUT + 1, 0, 0);
      do_read(32'h0000_020C, 0, TIMEOUT + 1, 0, 32'h5EED_0002, 0);
    join

    // reset in the middle of concurrent accesses
    wr_d = 0; wr_wt = 0; rd_d = 0; rd_wt = 0;
    exp_wreg.push_back('{16'h0300, 32'hCAFE_0000, 4'hF, 0});
    exp_rreg.push_back('{16'h0400, 0});
    axil.awaddr = 32'h300; axil.awvalid = 1'b1;
    axil.wdata = 32'hCAFE_0000; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
    axil.araddr = 32'h400; axil.arvalid = 1'b1;
    @(posedge clk); #1;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; axil.bready = 1'b1; axil.rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("en_after_rst", 64'({reg_wr_en, reg_rd_en}), 64'(0));
    check("addr_after_rst", 64'({reg_wr_addr, reg_rd_addr}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (axil.bvalid || axil.rvalid) n++;
    end
    check("no_resp_after_rst", 64'(n), 64'(0));
    @(posedge clk); #1;
    axil.bready = 1'b0; axil.rready = 1'b0;

    // randomized concurrent traffic
    fork
      begin
        for (int i = 0; i < 25; i++)
          do_write($urandom, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), rand_d(), rand_wt(), int'($urandom_range(0, 3)));
      end
      begin
        for (int j = 0; j < 25; j++)
          do_read($urandom, int'($urandom_range(0, 3)), rand_d(), rand_wt(), $urandom,
                  int'($urandom_range(0, 3)));
      end
    join

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 64'(exp_b.size() + exp_r.size() + exp_wreg.size() + exp_rreg.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (50000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: got 50000 cycles without completion, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule
